// File: rtl/mem_issue_sched.sv
// Memory issue scheduler: picks the oldest unblocked memory ops from the queue onto NPORTS issue ports.
// Latency: an entry selected in cycle N is presented on iss_v/iss_idx in cycle N+1.
// Backpressure: a port with iss_v & ~iss_rdy holds its index stable; a stomp on the held entry drops it.
module mem_issue_sched #(
  parameter int QENTRIES = 8,
  parameter int NPORTS   = 2,
  parameter int AWID     = 32,
  parameter int GRAN     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [$clog2(QENTRIES)-1:0]           head,
  input  logic [QENTRIES-1:0]                   memready,
  input  logic [QENTRIES-1:0]                   stomp,
  input  logic [QENTRIES-1:0]                   mem,
  input  logic [QENTRIES-1:0]                   load,
  input  logic [QENTRIES-1:0]                   fc,
  input  logic [QENTRIES-1:0]                   out,
  input  logic [QENTRIES-1:0]                   a1_v,
  input  logic [QENTRIES*AWID-1:0]              a1,
  input  logic [QENTRIES-1:0]                   done,
  output logic [NPORTS-1:0]                     iss_v,
  output logic [NPORTS*$clog2(QENTRIES)-1:0]    iss_idx,
  input  logic [NPORTS-1:0]                     iss_rdy,
  output logic [QENTRIES-1:0]                   inflight
);

  localparam int IW = $clog2(QENTRIES);

  logic [AWID-1:0]     addr      [QENTRIES];
  logic [IW-1:0]       rank      [QENTRIES];
  logic [IW-1:0]       port_idx  [NPORTS];
  logic [IW-1:0]       cand_idx  [NPORTS];
  logic [IW-1:0]       take_idx  [NPORTS];
  logic [QENTRIES-1:0] held;
  logic [QENTRIES-1:0] elig;
  logic [QENTRIES-1:0] blk;
  logic [QENTRIES-1:0] accept_set;
  logic [NPORTS-1:0]   port_free;
  logic [NPORTS-1:0]   port_take;

  // unpack flat buses and compute each entry's age rank relative to head
  always_comb begin
    for (int i = 0; i < QENTRIES; i++) begin
      addr[i] = a1[i*AWID +: AWID];
      rank[i] = IW'(i) - head;
    end
    for (int p = 0; p < NPORTS; p++) port_idx[p] = iss_idx[p*IW +: IW];
  end

  // entries currently parked on a port must not be picked again
  always_comb begin
    held = '0;
    for (int p = 0; p < NPORTS; p++)
      if (iss_v[p]) held[port_idx[p]] = 1'b1;
  end

  assign elig      = memready & ~stomp & ~inflight & ~held;
  assign port_free = ~iss_v | iss_rdy;

  // ordering hazards from older entries: unresolved/overlapping addresses, and store ordering
  always_comb begin
    blk = '0;
    for (int e = 0; e < QENTRIES; e++) begin
      for (int o = 0; o < QENTRIES; o++) begin
        if (rank[o] < rank[e]) begin
          if (mem[o] && !out[o] && !inflight[o] &&
              (!a1_v[o] || (((addr[o] ^ addr[e]) >> GRAN) == '0)))
            blk[e] = 1'b1;
          if (!load[e] && (fc[o] || (mem[o] && !inflight[o] && !out[o])))
            blk[e] = 1'b1;
        end
      end
    end
  end

  // oldest-first candidate walk, then map candidates onto free ports in port order
  always_comb begin
    int            nfree;
    int            ncand;
    int            k;
    logic          stop;
    logic [IW-1:0] e;
    nfree = 0;
    ncand = 0;
    k     = 0;
    stop  = 1'b0;
    e     = '0;
    for (int c = 0; c < NPORTS; c++) cand_idx[c] = '0;
    for (int p = 0; p < NPORTS; p++) if (port_free[p]) nfree++;
    for (int r = 0; r < QENTRIES; r++) begin
      e = head + IW'(r);
      if (!stop && elig[e]) begin
        // an eligible but blocked entry fences off everything younger
        if (blk[e]) stop = 1'b1;
        else if (ncand < nfree) begin
          for (int c = 0; c < NPORTS; c++) if (c == ncand) cand_idx[c] = e;
          ncand++;
        end
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      port_take[p] = 1'b0;
      take_idx[p]  = '0;
      if (port_free[p]) begin
        for (int c = 0; c < NPORTS; c++) begin
          if (c == k && c < ncand) begin
            port_take[p] = 1'b1;
            take_idx[p]  = cand_idx[c];
          end
        end
        k++;
      end
    end
  end

  // handshakes that actually mark an entry in flight (a stomped entry is never accepted)
  always_comb begin
    accept_set = '0;
    for (int p = 0; p < NPORTS; p++)
      if (iss_v[p] && iss_rdy[p] && !stomp[port_idx[p]]) accept_set[port_idx[p]] = 1'b1;
  end

  // in-flight set: accept sets, done and stomp clear (clears win over a same-cycle accept)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else        inflight <= (inflight | accept_set) & ~done & ~stomp;
  end

  // issue port registers: reload when free, hold under backpressure, drop on stomp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v   <= '0;
      iss_idx <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (port_free[p]) begin
          iss_v[p] <= port_take[p];
          if (port_take[p]) iss_idx[p*IW +: IW] <= take_idx[p];
        end else if (stomp[port_idx[p]]) begin
          iss_v[p] <= 1'b0;
        end
      end
    end
  end

endmodule
